hci_core_mux_static_ctrl: RTL and testbench

Sequencer for the static HCI core multiplexer: it decides which of NB_CHAN initiators owns the shared HCI port and drives the mux select. Ownership is held until the owner releases it, and the select only changes after every granted transaction has received its response. This makes switching safe for initiators that are not strictly alternative. It sits beside the static mux and observes the mux output-side handshake.

---
 rtl/hci_core_mux_static_ctrl_if.sv | 30 +++
 rtl/hci_core_mux_static_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hci_core_mux_static_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_core_mux_static_ctrl_if.sv
// -----------------------------------------------------------------------------
// hci_core_mux_static_ctrl_if
// Purpose : bundles the signals the static-mux controller observes: the
//           per-initiator ownership requests and the output-side handshake of
//           the static HCI mux.
// Signals : chan_req    [NB_CHAN] per-initiator ownership request (level)
//           out_req               mux output req
//           out_gnt               mux output gnt
//           out_r_valid           mux output r_valid
//           out_r_ready           mux output r_ready
// Modports: master drives the bundle (mux side / initiators),
//           slave observes it (the controller).
// -----------------------------------------------------------------------------
interface hci_core_mux_static_ctrl_if #(
   parameter int NB_CHAN = 2
);
   logic [NB_CHAN-1:0] chan_req;
   logic               out_req;
   logic               out_gnt;
   logic               out_r_valid;
   logic               out_r_ready;

   modport master (
      output chan_req, out_req, out_gnt, out_r_valid, out_r_ready
   );

   modport slave (
      input chan_req, out_req, out_gnt, out_r_valid, out_r_ready
   );
endinterface

// File: rtl/hci_core_mux_static_ctrl.sv
// -----------------------------------------------------------------------------
// hci_core_mux_static_ctrl
// Purpose : decides which of NB_CHAN initiators owns the shared HCI port and
//           drives the static mux select. Ownership is held until the owner
//           drops its request; the select is then held until every granted
//           transaction has been answered, so responses still route to the
//           old owner.
// Ports   : clk_i          clock
//           rst_ni         synchronous active-low reset
//           clear_i        synchronous soft clear (same effect as reset)
//           mux_i          observed requests and mux output handshake
//           sel_o          mux select (registered)
//           owner_valid_o  an owner is active
//           chan_gnt_o     one-hot ownership grant (registered)
//           outstanding_o  in-flight transaction count
//           busy_o         not idle, or transactions still in flight
//           err_o          sticky protocol error
// -----------------------------------------------------------------------------
module hci_core_mux_static_ctrl #(
   parameter int NB_CHAN         = 2,
   parameter int MAX_OUTSTANDING = 8,
   localparam int SEL_W          = $clog2(NB_CHAN),
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   hci_core_mux_static_ctrl_if.slave mux_i,
   output logic [SEL_W-1:0]          sel_o,
   output logic                      owner_valid_o,
   output logic [NB_CHAN-1:0]        chan_gnt_o,
   output logic [CNT_W-1:0]          outstanding_o,
   output logic                      busy_o,
   output logic                      err_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [SEL_W:0]   NB_EXT  = (SEL_W+1)'(NB_CHAN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e             state_q;
   logic [SEL_W-1:0]   sel_q;
   logic [NB_CHAN-1:0] chan_gnt_q;
   logic               owner_valid_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [SEL_W-1:0]   rr_q;
   logic               err_q;

   logic               inc;
   logic               dec;
   logic               cnt_err;
   logic               proto_err;
   logic               win_found;
   logic [SEL_W-1:0]   win_idx;
   logic [SEL_W-1:0]   rr_next;
   logic [SEL_W:0]     cand;
   logic [SEL_W:0]     win_plus1;

   // ------------------------------------------------------------------
   // Outstanding transaction tracking
   // ------------------------------------------------------------------
   assign inc = mux_i.out_req & mux_i.out_gnt;
   assign dec = mux_i.out_r_valid & mux_i.out_r_ready;

   always_comb begin
      cnt_d   = cnt_q;
      cnt_err = 1'b0;
      unique case ({inc, dec})
         2'b10: begin
            if (cnt_q == MAX_CNT) cnt_err = 1'b1;   // saturate
            else                  cnt_d   = cnt_q + 1'b1;
         end
         2'b01: begin
            if (cnt_q == '0) cnt_err = 1'b1;        // response with nothing in flight
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: cnt_d = cnt_q;                    // none, or inc and dec cancel
      endcase
   end

   // A transaction granted while nobody owns the port cannot be attributed.
   assign proto_err = inc & (state_q != OWNED);

   // ------------------------------------------------------------------
   // Round-robin winner: first requester at or above rr_q, wrapping.
   // Index arithmetic is one bit wider so the wrap works for any NB_CHAN.
   // ------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NB_CHAN; i++) begin
         cand = {1'b0, rr_q} + (SEL_W+1)'(i);
         if (cand >= NB_EXT) cand = cand - NB_EXT;
         if (!win_found && mux_i.chan_req[cand[SEL_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      win_plus1 = {1'b0, win_idx} + 1'b1;
      if (win_plus1 >= NB_EXT) win_plus1 = '0;
      rr_next = win_plus1[SEL_W-1:0];
   end

   // ------------------------------------------------------------------
   // Ownership FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q       <= IDLE;
         sel_q         <= '0;
         chan_gnt_q    <= '0;
         owner_valid_q <= 1'b0;
         cnt_q         <= '0;
         rr_q          <= '0;
         err_q         <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_q | cnt_err | proto_err;
         unique case (state_q)
            IDLE: begin
               // A stray transaction counted in IDLE keeps the select frozen
               // until its response comes back.
               if (win_found && (cnt_q == '0)) begin
                  state_q             <= OWNED;
                  sel_q               <= win_idx;
                  chan_gnt_q          <= '0;
                  chan_gnt_q[win_idx] <= 1'b1;
                  owner_valid_q       <= 1'b1;
                  rr_q                <= rr_next;
               end
            end
            OWNED: begin
               // No preemption: only the owner's own request matters here.
               if (!mux_i.chan_req[sel_q]) begin
                  state_q       <= DRAIN;
                  chan_gnt_q    <= '0;
                  owner_valid_q <= 1'b0;
               end
            end
            DRAIN: begin
               // sel_q is held so the remaining responses reach the old owner.
               if (cnt_d == '0) state_q <= IDLE;
            end
            default: begin
               state_q       <= IDLE;
               chan_gnt_q    <= '0;
               owner_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign sel_o         = sel_q;
   assign chan_gnt_o    = chan_gnt_q;
   assign owner_valid_o = owner_valid_q;
   assign outstanding_o = cnt_q;
   assign busy_o        = (state_q != IDLE) || (cnt_q != '0);
   assign err_o         = err_q;

endmodule

// File: tb/tb_hci_core_mux_static_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hci_core_mux_static_ctrl
// Randomised and directed stimulus; a behavioural ownership model predicts the
// outputs after every clock edge and queues them; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_hci_core_mux_static_ctrl;

   localparam int NB   = 4;
   localparam int MAXO = 3;
   localparam int SW   = $clog2(NB);
   localparam int CW   = $clog2(MAXO + 1);

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic clr     = 1'b0;
   always #5 clk = ~clk;

   hci_core_mux_static_ctrl_if #(.NB_CHAN(NB)) mif ();

   logic [SW-1:0] sel_o;
   logic          owner_valid_o;
   logic [NB-1:0] chan_gnt_o;
   logic [CW-1:0] outstanding_o;
   logic          busy_o;
   logic          err_o;

   hci_core_mux_static_ctrl #(.NB_CHAN(NB), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .clear_i       (clr),
      .mux_i         (mif),
      .sel_o         (sel_o),
      .owner_valid_o (owner_valid_o),
      .chan_gnt_o    (chan_gnt_o),
      .outstanding_o (outstanding_o),
      .busy_o        (busy_o),
      .err_o         (err_o)
   );

   typedef struct packed {
      logic [SW-1:0] sel;
      logic          ov;
      logic [NB-1:0] gnt;
      logic [CW-1:0] cnt;
      logic          busy;
      logic          err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Behavioural model: who owns the port, whether we wait for responses,
   // how many transactions are in flight, where round-robin resumes.
   int m_sel = 0, m_cnt = 0, m_rr = 0;
   bit m_owned = 0, m_drain = 0, m_err = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic model_step();
      int  inc, dec, nc, c;
      bit  found;
      inc = (mif.out_req && mif.out_gnt) ? 1 : 0;
      dec = (mif.out_r_valid && mif.out_r_ready) ? 1 : 0;
      if (!rst_n || clr) begin
         m_owned = 0; m_drain = 0; m_sel = 0; m_cnt = 0; m_rr = 0; m_err = 0;
      end else begin
         nc = m_cnt + inc - dec;
         if (inc == 1 && !m_owned) m_err = 1;
         if (nc > MAXO) begin nc = MAXO; m_err = 1; end
         if (nc < 0)    begin nc = 0;    m_err = 1; end
         if (m_owned) begin
            if (!mif.chan_req[m_sel]) begin m_owned = 0; m_drain = 1; end
         end else if (m_drain) begin
            if (nc == 0) m_drain = 0;
         end else if (m_cnt == 0) begin
            found = 0;
            for (int k = 0; k < NB; k++) begin
               c = (m_rr + k) % NB;
               if (!found && mif.chan_req[c]) begin
                  found = 1; m_sel = c; m_owned = 1; m_rr = (c + 1) % NB;
               end
            end
         end
         m_cnt = nc;
      end
   endtask

   // Apply current inputs for one clock: predict, queue, wait for negedge.
   task automatic tick();
      exp_t e;
      model_step();
      e.sel  = SW'(m_sel);
      e.ov   = m_owned;
      e.gnt  = m_owned ? (NB'(1) << m_sel) : '0;
      e.cnt  = CW'(m_cnt);
      e.busy = m_owned || m_drain || (m_cnt != 0);
      e.err  = m_err;
      exp_q.push_back(e);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_clear();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic txn_inc();
      mif.out_req = 1'b1; mif.out_gnt = 1'b1; tick();
      mif.out_req = 1'b0; mif.out_gnt = 1'b0;
   endtask

   task automatic txn_resp();
      mif.out_r_valid = 1'b1; mif.out_r_ready = 1'b1; tick();
      mif.out_r_valid = 1'b0; mif.out_r_ready = 1'b0;
   endtask

   task automatic wait_owned();
      int n = 0;
      while (!owner_valid_o && n < 20) begin tick(); n++; end
      chk("wait_owned_timeout", int'(owner_valid_o), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 20) begin tick(); n++; end
      chk("wait_idle_timeout", int'(busy_o), 0);
   endtask

   // Monitor: one predicted snapshot per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sel_o",         int'(sel_o),         int'(e.sel));
            chk("owner_valid_o", int'(owner_valid_o), int'(e.ov));
            chk("chan_gnt_o",    int'(chan_gnt_o),    int'(e.gnt));
            chk("outstanding_o", int'(outstanding_o), int'(e.cnt));
            chk("busy_o",        int'(busy_o),        int'(e.busy));
            chk("err_o",         int'(err_o),         int'(e.err));
            if (e.ov != owner_valid_o || e.cnt != outstanding_o || e.err != err_o || e.sel != sel_o)
               ;
            else if (mif.out_req || mif.out_r_valid || (e.gnt != 0 && cyc % 8 == 0))
               $display("txn cyc %0d: sel=%0d gnt=%b cnt=%0d err=%0d",
                        cyc, sel_o, chan_gnt_o, outstanding_o, err_o);
         end
      end
   end

   initial begin
      mif.chan_req    = '0;
      mif.out_req     = 1'b0;
      mif.out_gnt     = 1'b0;
      mif.out_r_valid = 1'b0;
      mif.out_r_ready = 1'b0;

      // Reset
      rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      chk("reset_sel", int'(sel_o), 0);
      chk("reset_busy", int'(busy_o), 0);

      // Single owner: grant one cycle after request, 3 txns, drain, idle.
      mif.chan_req = 4'b0001; tick();
      chk("single_gnt", int'(chan_gnt_o), 1);
      repeat (3) txn_inc();
      chk("single_cnt3", int'(outstanding_o), 3);
      repeat (3) txn_resp();
      mif.chan_req = 4'b0000; tick();
      chk("single_drain_gnt", int'(chan_gnt_o), 0);
      wait_idle();
      chk("single_err", int'(err_o), 0);

      // Round-robin fairness: all request, each owner does one txn then releases.
      do_clear();
      mif.chan_req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         wait_owned();
         chk("rr_order", int'(sel_o), r % NB);
         txn_inc(); txn_resp();
         mif.chan_req = 4'b1111 & ~(NB'(1) << sel_o);
         tick(); tick();
         mif.chan_req = 4'b1111;
      end

      // Drain hold: owner 0 releases with 2 outstanding while channel 1 waits.
      do_clear();
      mif.chan_req = 4'b0011; wait_owned();
      txn_inc(); txn_inc();
      mif.chan_req = 4'b0010;
      tick(); tick();
      chk("drain_hold_sel", int'(sel_o), 0);
      txn_resp(); tick();
      chk("drain_hold_sel2", int'(sel_o), 0);
      txn_resp();
      wait_owned();
      chk("drain_new_owner", int'(sel_o), 1);

      // Simultaneous inc/dec keep the count, then saturation.
      do_clear();
      mif.chan_req = 4'b0001; wait_owned();
      txn_inc();
      mif.out_req = 1'b1; mif.out_gnt = 1'b1; mif.out_r_valid = 1'b1; mif.out_r_ready = 1'b1;
      repeat (10) tick();
      mif.out_r_valid = 1'b0; mif.out_r_ready = 1'b0; mif.out_req = 1'b0; mif.out_gnt = 1'b0;
      chk("incdec_cnt", int'(outstanding_o), 1);
      chk("incdec_err", int'(err_o), 0);
      repeat (3) txn_inc();
      chk("sat_cnt", int'(outstanding_o), MAXO);
      chk("sat_err", int'(err_o), 1);

      // Protocol errors: inc in IDLE, dec at zero.
      mif.chan_req = 4'b0000; do_clear();
      txn_inc();
      chk("idle_inc_err", int'(err_o), 1);
      chk("idle_inc_cnt", int'(outstanding_o), 1);
      do_clear();
      txn_resp();
      chk("underflow_err", int'(err_o), 1);
      chk("underflow_cnt", int'(outstanding_o), 0);

      // Clear mid-drain with 3 outstanding.
      do_clear();
      mif.chan_req = 4'b0001; wait_owned();
      repeat (3) txn_inc();
      mif.chan_req = 4'b0000; tick();
      chk("pre_clear_busy", int'(busy_o), 1);
      do_clear();
      chk("clear_cnt", int'(outstanding_o), 0);
      chk("clear_busy", int'(busy_o), 0);
      mif.chan_req = 4'b0010; tick();
      chk("post_clear_gnt", int'(chan_gnt_o), 2);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) mif.chan_req[$urandom_range(0, NB-1)] ^= 1'b1;
         mif.out_req     = ($urandom_range(0, 3) == 0);
         mif.out_gnt     = ($urandom_range(0, 1) == 0);
         mif.out_r_valid = ($urandom_range(0, 2) == 0);
         mif.out_r_ready = ($urandom_range(0, 1) == 0);
         clr             = ($urandom_range(0, 63) == 0);
         rst_n           = !($urandom_range(0, 127) == 0);
         tick();
      end
      clr = 1'b0; rst_n = 1'b1;
      mif.chan_req = '0; mif.out_req = 1'b0; mif.out_gnt = 1'b0;
      mif.out_r_valid = 1'b0; mif.out_r_ready = 1'b0;
      tick(); tick();

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
